// File: rtl/a1000_sram_bridge.sv
// a1000_sram_bridge: oversampled A1000 DRAM strobe decoder driving an async SRAM.
// Inputs are synchronised and glitch-filtered; every SRAM-facing output is registered.
module a1000_sram_bridge #(
  parameter int DRA_W        = 8,
  parameter int NUM_BANKS    = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_CYCLES  = 2,
  parameter int SETUP_CYCLES = 1,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ras_n,
  input  logic                      rrw_n,
  input  logic [NUM_BANKS-1:0]      casl_n,
  input  logic [NUM_BANKS-1:0]      casu_n,
  input  logic [DRA_W-1:0]          dra,
  output logic [BANK_W+2*DRA_W-1:0] sram_a,
  output logic                      ce2,
  output logic                      ce1_l_n,
  output logic                      ce1_u_n,
  output logic                      oe_n,
  output logic                      we_n,
  output logic                      cbr_refresh,
  output logic                      err_multi_bank
);

  localparam int NS   = 2 + 2 * NUM_BANKS;
  localparam int L_IN = SYNC_STAGES + FILT_CYCLES;
  localparam int FC_W = $clog2(FILT_CYCLES + 1);
  localparam int SC_W = $clog2(SETUP_CYCLES + 1);
  localparam int AW   = BANK_W + 2 * DRA_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW     = 3'd1,
    SETUP   = 3'd2,
    ACTIVE  = 3'd3,
    REFRESH = 3'd4
  } state_t;

  logic [NS-1:0]          raw_s;
  logic [NS-1:0]          sync_r [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_r;
  logic [NS-1:0]          flt_r;
  logic [FC_W-1:0]        fcnt_r [NS];
  logic [DRA_W-1:0]       dra_r [L_IN];
  logic [NUM_BANKS-1:0]   casl_f_s, casu_f_s, act_s;
  logic                   cas_any_s, multi_s;
  logic                   ras_fall_s, ras_rise_s, cas_rise_s, cas_fall_s;
  logic [BANK_W-1:0]      bank_s;
  logic                   lane_l_s, lane_u_s;
  state_t                 state_r;
  logic                   ras_prev_r, cas_prev_r, armed_r;
  logic                   read_r, lane_l_r, lane_u_r;
  logic [SC_W-1:0]        scnt_r;

  // Bit 0 is RAS, bit 1 is R/W, then the lower and upper CAS lanes.
  assign raw_s = {casu_n, casl_n, rrw_n, ras_n};

  // Synchroniser chain plus the matching address delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {NS{1'b1}};
      for (int i = 0; i < L_IN; i++) dra_r[i] <= {DRA_W{1'b0}};
      vld_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r[0] <= raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      dra_r[0] <= dra;
      for (int i = 1; i < L_IN; i++) dra_r[i] <= dra_r[i-1];
      vld_r <= {vld_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Per-signal filter: accept a new level only after FILT_CYCLES equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_r <= {NS{1'b1}};
      for (int i = 0; i < NS; i++) fcnt_r[i] <= {FC_W{1'b0}};
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (sync_r[SYNC_STAGES-1][i] == flt_r[i]) begin
          fcnt_r[i] <= {FC_W{1'b0}};
        end else if (fcnt_r[i] == FC_W'(FILT_CYCLES - 1)) begin
          flt_r[i]  <= sync_r[SYNC_STAGES-1][i];
          fcnt_r[i] <= {FC_W{1'b0}};
        end else begin
          fcnt_r[i] <= fcnt_r[i] + FC_W'(1);
        end
      end
    end
  end

  assign casl_f_s   = flt_r[2 +: NUM_BANKS];
  assign casu_f_s   = flt_r[2 + NUM_BANKS +: NUM_BANKS];
  assign act_s      = ~casl_f_s | ~casu_f_s;
  assign cas_any_s  = |act_s;
  assign multi_s    = ($countones(act_s) > 32'd1);
  assign ras_fall_s = ras_prev_r & ~flt_r[0];
  assign ras_rise_s = ~ras_prev_r & flt_r[0];
  assign cas_rise_s = cas_any_s & ~cas_prev_r;
  assign cas_fall_s = ~cas_any_s & cas_prev_r;

  // Lowest-index active bank wins; its lanes become the latched lane enables.
  always_comb begin
    bank_s   = {BANK_W{1'b0}};
    lane_l_s = 1'b0;
    lane_u_s = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      bank_s   = act_s[i] ? BANK_W'(i) : bank_s;
      lane_l_s = act_s[i] ? ~casl_f_s[i] : lane_l_s;
      lane_u_s = act_s[i] ? ~casu_f_s[i] : lane_u_s;
    end
  end

  // Access sequencer with registered SRAM strobes; a RAS rise always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      sram_a         <= {AW{1'b0}};
      ce2            <= 1'b0;
      ce1_l_n        <= 1'b1;
      ce1_u_n        <= 1'b1;
      oe_n           <= 1'b1;
      we_n           <= 1'b1;
      cbr_refresh    <= 1'b0;
      err_multi_bank <= 1'b0;
      ras_prev_r     <= 1'b1;
      cas_prev_r     <= 1'b0;
      armed_r        <= 1'b0;
      read_r         <= 1'b1;
      lane_l_r       <= 1'b0;
      lane_u_r       <= 1'b0;
      scnt_r         <= {SC_W{1'b0}};
    end else begin
      cbr_refresh    <= 1'b0;
      err_multi_bank <= 1'b0;
      ras_prev_r     <= flt_r[0];
      cas_prev_r     <= cas_any_s;
      // A RAS that was already low at reset release must be seen high first.
      if (vld_r[SYNC_STAGES-1] && sync_r[SYNC_STAGES-1][0]) armed_r <= 1'b1;
      if (ras_rise_s) begin
        state_r <= IDLE;
        ce2     <= 1'b0;
        ce1_l_n <= 1'b1;
        ce1_u_n <= 1'b1;
        oe_n    <= 1'b1;
        we_n    <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (ras_fall_s && armed_r) begin
              if (cas_any_s) begin
                state_r     <= REFRESH;
                cbr_refresh <= 1'b1;
              end else begin
                state_r            <= ROW;
                ce2                <= 1'b1;
                sram_a[DRA_W-1:0]  <= dra_r[L_IN-1];
              end
            end
          end
          ROW: begin
            if (cas_rise_s) begin
              sram_a[2*DRA_W-1:DRA_W] <= dra_r[L_IN-1];
              sram_a[AW-1:2*DRA_W]    <= bank_s;
              read_r                  <= flt_r[1];
              lane_l_r                <= lane_l_s;
              lane_u_r                <= lane_u_s;
              err_multi_bank          <= multi_s;
              scnt_r                  <= {SC_W{1'b0}};
              state_r                 <= SETUP;
            end
          end
          SETUP: begin
            if (cas_fall_s) begin
              state_r <= ROW;
            end else if (scnt_r == SC_W'(SETUP_CYCLES - 1)) begin
              state_r <= ACTIVE;
              ce1_l_n <= ~lane_l_r;
              ce1_u_n <= ~lane_u_r;
              oe_n    <= ~read_r;
              we_n    <= read_r;
            end else begin
              scnt_r <= scnt_r + SC_W'(1);
            end
          end
          ACTIVE: begin
            if (cas_fall_s) begin
              state_r <= ROW;
              ce1_l_n <= 1'b1;
              ce1_u_n <= 1'b1;
              oe_n    <= 1'b1;
              we_n    <= 1'b1;
            end
          end
          REFRESH: state_r <= REFRESH;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a1000_sram_bridge.sv
// Directed bench for a1000_sram_bridge: expectations queued at stimulus time and
// popped at the DUT output edge they describe.
module tb_a1000_sram_bridge;

  localparam int DRA_W = 8;
  localparam int NB    = 2;
  localparam int AW    = 1 + 2 * DRA_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ras_n = 1'b1;
  logic          rrw_n = 1'b1;
  logic [NB-1:0] casl_n = 2'b11;
  logic [NB-1:0] casu_n = 2'b11;
  logic [DRA_W-1:0] dra = 8'h00;
  logic [AW-1:0] sram_a;
  logic ce2, ce1_l_n, ce1_u_n, oe_n, we_n, cbr_refresh, err_multi_bank;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int oe_p = 0, we_p = 0, cbr_p = 0, err_p = 0, ce2_r = 0, ce2_f = 0, both = 0;
  logic oe_q = 1'b1, we_q = 1'b1, ce2_q = 1'b0;
  int base_a, base_b;

  a1000_sram_bridge #(
    .DRA_W(DRA_W), .NUM_BANKS(NB), .SYNC_STAGES(2), .FILT_CYCLES(2), .SETUP_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ras_n(ras_n), .rrw_n(rrw_n),
    .casl_n(casl_n), .casu_n(casu_n), .dra(dra),
    .sram_a(sram_a), .ce2(ce2), .ce1_l_n(ce1_l_n), .ce1_u_n(ce1_u_n),
    .oe_n(oe_n), .we_n(we_n), .cbr_refresh(cbr_refresh), .err_multi_bank(err_multi_bank)
  );

  always #5 clk = ~clk;

  // Pulse and overlap counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (oe_q && !oe_n) oe_p <= oe_p + 1;
    if (we_q && !we_n) we_p <= we_p + 1;
    if (!ce2_q && ce2) ce2_r <= ce2_r + 1;
    if (ce2_q && !ce2) ce2_f <= ce2_f + 1;
    if (cbr_refresh) cbr_p <= cbr_p + 1;
    if (err_multi_bank) err_p <= err_p + 1;
    if (!oe_n && !we_n) both <= both + 1;
    oe_q  <= oe_n;
    we_q  <= we_n;
    ce2_q <= ce2;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Called right after an input change at a negedge: ends #1 after edge k,
  // scrambling dra once edge 0 has sampled it.
  task automatic wait_edge(input int k);
    @(posedge clk);
    @(negedge clk);
    dra = dra ^ 8'hFF;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic next_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    expect_v({p, "_sram_a"}, 32'h0);
    expect_v({p, "_ce2"}, 32'h0);
    expect_v({p, "_ce1_l_n"}, 32'h1);
    expect_v({p, "_ce1_u_n"}, 32'h1);
    expect_v({p, "_oe_n"}, 32'h1);
    expect_v({p, "_we_n"}, 32'h1);
    expect_v({p, "_cbr"}, 32'h0);
    expect_v({p, "_err"}, 32'h0);
    chk(32'(sram_a)); chk(32'(ce2)); chk(32'(ce1_l_n)); chk(32'(ce1_u_n));
    chk(32'(oe_n)); chk(32'(we_n)); chk(32'(cbr_refresh)); chk(32'(err_multi_bank));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_reset("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: read on bank 1, lower lane
    dra = 8'h12; ras_n = 1'b0;
    expect_v("rd_ce2_e3", 32'h0); expect_v("rd_ce2_e4", 32'h1); expect_v("rd_row", 32'h00012);
    wait_edge(3); chk(32'(ce2));
    next_edge(1); chk(32'(ce2)); chk(32'(sram_a));
    repeat (3) @(negedge clk);
    casl_n = 2'b01; dra = 8'h34;
    expect_v("rd_oe_e4", 32'h1); expect_v("rd_addr", 32'h13412);
    expect_v("rd_oe_e5", 32'h0); expect_v("rd_ce1l_e5", 32'h0);
    expect_v("rd_ce1u_e5", 32'h1); expect_v("rd_we_e5", 32'h1);
    wait_edge(4); chk(32'(oe_n)); chk(32'(sram_a));
    next_edge(1); chk(32'(oe_n)); chk(32'(ce1_l_n)); chk(32'(ce1_u_n)); chk(32'(we_n));
    repeat (3) @(negedge clk);
    casl_n = 2'b11;
    expect_v("rd_oe_hold_e3", 32'h0); expect_v("rd_oe_off_e4", 32'h1);
    expect_v("rd_ce1l_off_e4", 32'h1); expect_v("rd_ce2_kept", 32'h1);
    wait_edge(3); chk(32'(oe_n));
    next_edge(1); chk(32'(oe_n)); chk(32'(ce1_l_n)); chk(32'(ce2));
    @(negedge clk);
    ras_n = 1'b1;
    expect_v("rd_ce2_hold_e3", 32'h1); expect_v("rd_ce2_off_e4", 32'h0);
    wait_edge(3); chk(32'(ce2));
    next_edge(1); chk(32'(ce2));
    expect_v("rd_oe_pulses", 32'd1); expect_v("rd_we_pulses", 32'd0);
    chk(32'(oe_p)); chk(32'(we_p));

    // 2: write on bank 0, both lanes
    repeat (4) @(negedge clk);
    rrw_n = 1'b0; dra = 8'hAA; ras_n = 1'b0;
    base_a = oe_p;
    wait_edge(6);
    @(negedge clk);
    casl_n = 2'b10; casu_n = 2'b10; dra = 8'h55;
    expect_v("wr_addr", 32'h055AA); expect_v("wr_we_e4", 32'h1);
    expect_v("wr_we_e5", 32'h0); expect_v("wr_ce1l_e5", 32'h0); expect_v("wr_ce1u_e5", 32'h0);
    wait_edge(4); chk(32'(sram_a)); chk(32'(we_n));
    next_edge(1); chk(32'(we_n)); chk(32'(ce1_l_n)); chk(32'(ce1_u_n));
    repeat (3) @(negedge clk);
    casl_n = 2'b11; casu_n = 2'b11;
    expect_v("wr_we_hold_e3", 32'h0); expect_v("wr_we_off_e4", 32'h1);
    expect_v("wr_ce1l_off", 32'h1); expect_v("wr_ce1u_off", 32'h1); expect_v("wr_oe_off", 32'h1);
    wait_edge(3); chk(32'(we_n));
    next_edge(1); chk(32'(we_n)); chk(32'(ce1_l_n)); chk(32'(ce1_u_n)); chk(32'(oe_n));
    @(negedge clk);
    ras_n = 1'b1; rrw_n = 1'b1;
    wait_edge(6);
    expect_v("wr_no_oe", 32'(base_a)); chk(32'(oe_p));

    // 3: page mode, three upper-lane reads on bank 1 under one RAS
    @(negedge clk);
    dra = 8'h10; ras_n = 1'b0;
    wait_edge(6);
    base_a = oe_p; base_b = ce2_f;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      casu_n = 2'b01; dra = 8'(c);
      expect_v($sformatf("pg%0d_addr", c), 32'h10010 | (32'(c) << 8));
      expect_v($sformatf("pg%0d_ce1u_on", c), 32'h0);
      expect_v($sformatf("pg%0d_oe_on", c), 32'h0);
      wait_edge(4); chk(32'(sram_a));
      next_edge(1); chk(32'(ce1_u_n)); chk(32'(oe_n));
      repeat (2) @(negedge clk);
      casu_n = 2'b11;
      expect_v($sformatf("pg%0d_ce1u_off", c), 32'h1);
      expect_v($sformatf("pg%0d_ce2", c), 32'h1);
      wait_edge(4); chk(32'(ce1_u_n)); chk(32'(ce2));
    end
    expect_v("pg_oe_pulses", 32'(base_a + 3)); expect_v("pg_ce2_falls", 32'(base_b));
    chk(32'(oe_p)); chk(32'(ce2_f));
    @(negedge clk);
    ras_n = 1'b1;
    wait_edge(6);

    // 4: CAS-before-RAS refresh
    @(negedge clk);
    casl_n = 2'b10;
    wait_edge(6);
    base_a = cbr_p; base_b = ce2_r;
    @(negedge clk);
    ras_n = 1'b0;
    expect_v("cbr_e3", 32'h0); expect_v("cbr_e4", 32'h1); expect_v("cbr_e5", 32'h0);
    wait_edge(3); chk(32'(cbr_refresh));
    next_edge(1); chk(32'(cbr_refresh));
    next_edge(1); chk(32'(cbr_refresh));
    next_edge(8);
    expect_v("cbr_ce2", 32'h0); expect_v("cbr_oe", 32'h1); expect_v("cbr_we", 32'h1);
    expect_v("cbr_ce1l", 32'h1);
    chk(32'(ce2)); chk(32'(oe_n)); chk(32'(we_n)); chk(32'(ce1_l_n));
    @(negedge clk);
    ras_n = 1'b1;
    wait_edge(6);
    @(negedge clk);
    casl_n = 2'b11;
    wait_edge(6);
    expect_v("cbr_pulses", 32'(base_a + 1)); expect_v("cbr_no_ce2", 32'(base_b));
    chk(32'(cbr_p)); chk(32'(ce2_r));

    // 5a: one-clock RAS glitch
    base_a = ce2_r;
    @(negedge clk);
    ras_n = 1'b0;
    @(negedge clk);
    ras_n = 1'b1;
    next_edge(10);
    expect_v("glitch_ce2", 32'h0); expect_v("glitch_no_rise", 32'(base_a));
    chk(32'(ce2)); chk(32'(ce2_r));

    // 5b: two banks' lower CAS together
    @(negedge clk);
    dra = 8'h21; ras_n = 1'b0;
    wait_edge(6);
    base_a = err_p;
    @(negedge clk);
    casl_n = 2'b00; dra = 8'h77;
    expect_v("mb_err_e3", 32'h0); expect_v("mb_err_e4", 32'h1); expect_v("mb_addr", 32'h07721);
    expect_v("mb_err_e5", 32'h0); expect_v("mb_oe_e5", 32'h0); expect_v("mb_ce1l_e5", 32'h0);
    wait_edge(3); chk(32'(err_multi_bank));
    next_edge(1); chk(32'(err_multi_bank)); chk(32'(sram_a));
    next_edge(1); chk(32'(err_multi_bank)); chk(32'(oe_n)); chk(32'(ce1_l_n));
    @(negedge clk);
    casl_n = 2'b11;
    wait_edge(6);
    @(negedge clk);
    ras_n = 1'b1;
    wait_edge(6);
    expect_v("mb_err_pulses", 32'(base_a + 1)); chk(32'(err_p));

    // 6: asynchronous reset in the middle of a write
    @(negedge clk);
    rrw_n = 1'b0; dra = 8'h33; ras_n = 1'b0;
    wait_edge(6);
    @(negedge clk);
    casl_n = 2'b10; dra = 8'h44;
    expect_v("rst_pre_we", 32'h0);
    wait_edge(5); chk(32'(we_n));
    #2 rst_n = 1'b0;
    #1 check_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_a = ce2_r; base_b = we_p;
    repeat (15) @(negedge clk);
    expect_v("rst_stuck_ce2", 32'(base_a)); expect_v("rst_stuck_we", 32'(base_b));
    chk(32'(ce2_r)); chk(32'(we_p));
    ras_n = 1'b1; casl_n = 2'b11; rrw_n = 1'b1;
    repeat (8) @(negedge clk);
    dra = 8'h01; ras_n = 1'b0;
    expect_v("rst_rearm_ce2", 32'h1); expect_v("rst_rearm_row", 32'h00001);
    wait_edge(4); chk(32'(ce2)); chk(32'(sram_a));
    @(negedge clk);
    ras_n = 1'b1;
    wait_edge(6);

    expect_v("oe_we_overlap", 32'd0); chk(32'(both));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a1000_sram_bridge.md
# a1000_sram_bridge

Synchronous, parametrised successor to the Front-RAM SRAM glue. It oversamples the A1000 DRAM strobes (/RAS, per-bank /CASL and /CASU, RRW, DRA) on a local clock and drives an async SRAM with registered, glitch-free CE/OE/WE. Compared with the existing asynchronous glue it adds an input glitch filter, configurable bank count, page-mode (multiple CAS per RAS) re-latching, CAS-before-RAS refresh detection and a multi-bank error flag. It sits between the A1000 DRAM socket and the SRAM array, with one instance per SRAM group.

## Interface
Parameters:
- DRA_W, 8: multiplexed DRAM address width.
- NUM_BANKS, 2: CAS bank groups, 1..4. BANK_W = max(1, clog2(NUM_BANKS)).
- SYNC_STAGES, 2: synchroniser depth on all inputs, ≥2.
- FILT_CYCLES, 2: consecutive equal samples required to accept a strobe change, ≥1.
- SETUP_CYCLES, 1: clocks from address latch to strobe assertion, ≥1.

Ports:
- clk  in  1  oversampling clock, ≥4× the DRAM strobe rate.
- rst_n  in  1  asynchronous active-low reset.
- ras_n  in  1  DRAM /RAS.
- rrw_n  in  1  DRAM R/W, 1 = read.
- casl_n  in  NUM_BANKS  lower-lane /CAS per bank.
- casu_n  in  NUM_BANKS  upper-lane /CAS per bank.
- dra  in  DRA_W  multiplexed row/column address.
- sram_a  out  BANK_W+2*DRA_W  SRAM address {bank, col, row}.
- ce2  out  1  SRAM CE2, active high.
- ce1_l_n, ce1_u_n  out  1 each  lane chip enables.
- oe_n, we_n  out  1 each  SRAM output enable and write enable.
- cbr_refresh  out  1  one-clock pulse per detected CBR refresh.
- err_multi_bank  out  1  one-clock pulse when more than one bank's CAS is active at a latch.

## Operation
- Inputs:
  - All strobes and rrw_n pass through SYNC_STAGES flops (reset value 1), then a per-signal filter. The filtered value changes only after FILT_CYCLES equal samples.
  - dra passes through a matching delay, so the latched dra is the sample taken on the same clk edge as the qualifying strobe's first low sample.
- cas_any = OR over banks of (~casl_n | ~casu_n), taken after filtering.
- FSM states:
  - IDLE:
    - Filtered RAS falls with cas_any=0: latch row, go to ROW.
    - Filtered RAS falls with cas_any=1: go to REFRESH and pulse cbr_refresh.
  - ROW: on filtered cas_any rise, in the same clock:
    - Latch col = dra.
    - Latch bank = lowest-index active bank.
    - Latch read = rrw_n.
    - Latch lane enables.
    - If more than one bank is active, pulse err_multi_bank.
    - Go to SETUP.
  - SETUP: count SETUP_CYCLES, then go to ACTIVE.
  - ACTIVE: the selected lane CE1 and OE (read=1) or WE (read=0) are asserted. When cas_any falls, deassert all and go to ROW, ready for the next page-mode CAS, which re-latches col, bank, read and lanes.
  - REFRESH: no SRAM strobes. Wait for filtered RAS rise.
- A filtered RAS rise in any state returns the FSM to IDLE on that clock and deasserts ce2 and all strobes.
- ce2 = 1 in ROW, SETUP and ACTIVE.
- OE and WE are never both asserted. read does not change while in ACTIVE.
- CAS activity while RAS is high, other than the CBR case, is ignored.

## Timing
- Edge numbering: edge 0 is the first clk edge that samples an input at its new level. L_IN = SYNC_STAGES + FILT_CYCLES.
- ce2 rises at edge L_IN after /RAS falls and falls at edge L_IN after /RAS rises.
- sram_a updates at edge L_IN of the qualifying strobe, for both row and col.
- CE1/OE/WE assert at edge L_IN+SETUP_CYCLES after /CAS falls and deassert at edge L_IN after /CAS rises.
- cbr_refresh and err_multi_bank are single-clock pulses at edge L_IN.
- Pulses narrower than FILT_CYCLES clocks after the synchroniser produce no state change.
- If CAS rises during SETUP, strobes never assert and the FSM returns to ROW.
- Reset values: sram_a=0, ce2=0, ce1_l_n=1, ce1_u_n=1, oe_n=1, we_n=1, cbr_refresh=0, err_multi_bank=0, FSM=IDLE.
  - rst_n assertion mid-access forces these values immediately.
  - After release, the FSM waits in IDLE for a fresh filtered RAS fall. An already-low RAS is not accepted until it has been seen high.

## Test plan
Defaults for all scenarios: DRA_W=8, NUM_BANKS=2, SYNC=2, FILT=2, SETUP=1, so L_IN=4.

1. Read: RAS low with dra=0x12, then casl_n[1]=0 with dra=0x34 and rrw_n=1.
   - Required: ce2=1 at edge 4 of RAS; sram_a=0x13412.
   - oe_n=0 and ce1_l_n=0 at edge 5 of CAS; ce1_u_n=1, we_n=1 throughout.
2. Write on bank 0, both lanes: rrw_n=0, row=0xAA, col=0x55.
   - Required: sram_a=0x055AA; we_n=0 at edge 5; oe_n=1 throughout; all strobes high at edge 4 after CAS rises.
3. Page mode: one RAS with three CAS cycles, col=0x01, 0x02, 0x03.
   - Required: three separate strobe pulses with sram_a[15:8] = 01, 02, 03; ce2 held high across all three.
4. CBR refresh: CAS low, then RAS low.
   - Required: cbr_refresh pulses once; ce2, OE, WE and CE1 stay inactive until RAS rises.
5. Glitch and error cases:
   - A 1-clock low glitch on ras_n: no ce2.
   - casl_n=2'b00 simultaneously: bank=0 latched and err_multi_bank pulses once.
6. Reset during ACTIVE write: all outputs reach reset values with no clk edge; no strobe asserts until RAS goes high then low again.
